// File: rtl/quad_encoder_array.sv
// quad_encoder_array
// Multi-channel 4x quadrature encoder interface. Every channel has its own
// input synchroniser, glitch filter, Gray-code decoder, signed wrapping
// position counter, saturating distance counter and sticky error flag.
// A shared snapshot port latches all position counts in the same cycle.
//
// Optional feature: define ENC_VELOCITY_EN to build the per-channel velocity
// estimator (shared window counter, per-channel base, vel / vel_valid ports).
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   quad_a/quad_b asynchronous encoder phases, one bit per channel
//   zero_cntrs    synchronous per-channel clear of count/pos_count/err
//   snap_req      one-cycle request to latch every count
//   count         live signed position, channel 0 in the LSBs
//   pos_count     live saturating edge count (distance)
//   direction     1 = forward, 0 = reverse, from the last valid edge
//   err           sticky illegal-transition flag
//   snap_count    counts captured by the last snap_req
//   snap_valid    one-cycle pulse when snap_count has been refreshed
//   vel/vel_valid signed counts per window and its strobe (ENC_VELOCITY_EN)
module quad_encoder_array #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int VEL_PERIOD  = 100000,
  parameter int VEL_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       quad_a,
  input  logic [NUM_CH-1:0]       quad_b,
  input  logic [NUM_CH-1:0]       zero_cntrs,
  input  logic                    snap_req,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic [NUM_CH*CNT_W-1:0] pos_count,
  output logic [NUM_CH-1:0]       direction,
  output logic [NUM_CH-1:0]       err,
  output logic [NUM_CH*CNT_W-1:0] snap_count,
  output logic                    snap_valid
`ifdef ENC_VELOCITY_EN
  ,
  output logic [NUM_CH*VEL_W-1:0] vel,
  output logic                    vel_valid
`endif
);

  localparam int FCW = $clog2(FILT_LEN + 1);

  logic snap_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) snap_valid_q <= 1'b0;
    else     snap_valid_q <= snap_req;
  end

  assign snap_valid = snap_valid_q;

`ifdef ENC_VELOCITY_EN
  localparam int PW = $clog2(VEL_PERIOD);
  localparam int DW = (CNT_W > VEL_W) ? CNT_W : VEL_W;

  logic [PW-1:0] per_q;
  logic          per_term;
  logic          vel_valid_q;

  // Clamp a wrapped count difference into the signed VEL_W range.
  function automatic logic signed [VEL_W-1:0] sat_vel(input logic signed [CNT_W-1:0] d);
    logic signed [DW-1:0] x;
    logic signed [DW-1:0] vmax;
    logic signed [DW-1:0] vmin;
    x    = DW'(d);
    vmax = DW'({1'b0, {(VEL_W-1){1'b1}}});
    vmin = ~vmax;
    if (x > vmax)      sat_vel = vmax[VEL_W-1:0];
    else if (x < vmin) sat_vel = vmin[VEL_W-1:0];
    else               sat_vel = x[VEL_W-1:0];
  endfunction

  assign per_term = (per_q == PW'(VEL_PERIOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_q       <= '0;
      vel_valid_q <= 1'b0;
    end else begin
      per_q       <= per_term ? '0 : per_q + PW'(1);
      vel_valid_q <= per_term;
    end
  end

  assign vel_valid = vel_valid_q;
`else
  logic unused_vel_cfg;
  assign unused_vel_cfg = (VEL_PERIOD > 1) ^ (VEL_W > 1);
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0] in_ab;
    logic [1:0] filt;

    assign in_ab = {quad_a[i], quad_b[i]};

    // Index 1 is phase A, index 0 is phase B.
    for (genvar p = 0; p < 2; p++) begin : g_ph
      logic [SYNC_STAGES-1:0] sync_q;
      logic [FCW-1:0]         fcnt_q;
      logic                   filt_q;

      // The synchronised value must differ from the accepted value on
      // FILT_LEN consecutive edges before it is taken; any reversion
      // restarts the count.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_q <= '0;
          fcnt_q <= '0;
          filt_q <= 1'b0;
        end else begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], in_ab[p]};
          if (sync_q[SYNC_STAGES-1] == filt_q) begin
            fcnt_q <= '0;
          end else if (fcnt_q == FCW'(FILT_LEN - 1)) begin
            filt_q <= sync_q[SYNC_STAGES-1];
            fcnt_q <= '0;
          end else begin
            fcnt_q <= fcnt_q + FCW'(1);
          end
        end
      end

      assign filt[p] = filt_q;
    end

    logic [1:0]              ab_p1_q;
    logic [1:0]              ab_p2_q;
    logic                    fwd;
    logic                    rev;
    logic                    ill;
    logic signed [CNT_W-1:0] count_q;
    logic signed [CNT_W-1:0] count_d;
    logic [CNT_W-1:0]        pos_q;
    logic [CNT_W-1:0]        pos_d;
    logic                    dir_q;
    logic                    dir_d;
    logic                    err_q;
    logic                    err_d;
    logic signed [CNT_W-1:0] snap_q;

    // Gray order 00->01->11->10->00 is forward; both bits flipping is illegal.
    always_comb begin
      fwd = 1'b0;
      rev = 1'b0;
      ill = 1'b0;
      case ({ab_p2_q, ab_p1_q})
        4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd = 1'b1;
        4'b0010, 4'b1011, 4'b1101, 4'b0100: rev = 1'b1;
        4'b0011, 4'b1100, 4'b0110, 4'b1001: ill = 1'b1;
        default: ;
      endcase
    end

    always_comb begin
      count_d = count_q;
      pos_d   = pos_q;
      dir_d   = dir_q;
      err_d   = err_q;
      if (zero_cntrs[i]) begin
        count_d = '0;
        pos_d   = '0;
        err_d   = 1'b0;
      end else if (fwd || rev) begin
        count_d = fwd ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
        pos_d   = (&pos_q) ? pos_q : pos_q + CNT_W'(1);
        dir_d   = fwd;
      end else if (ill) begin
        err_d   = 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ab_p1_q <= 2'b00;
        ab_p2_q <= 2'b00;
        count_q <= '0;
        pos_q   <= '0;
        dir_q   <= 1'b0;
        err_q   <= 1'b0;
        snap_q  <= '0;
      end else begin
        ab_p1_q <= filt;
        ab_p2_q <= ab_p1_q;
        count_q <= count_d;
        pos_q   <= pos_d;
        dir_q   <= dir_d;
        err_q   <= err_d;
        if (snap_req) snap_q <= count_q;
      end
    end

    assign count[i*CNT_W +: CNT_W]      = count_q;
    assign pos_count[i*CNT_W +: CNT_W]  = pos_q;
    assign direction[i]                 = dir_q;
    assign err[i]                       = err_q;
    assign snap_count[i*CNT_W +: CNT_W] = snap_q;

`ifdef ENC_VELOCITY_EN
    logic signed [CNT_W-1:0] base_q;
    logic signed [VEL_W-1:0] vel_q;
    logic signed [CNT_W-1:0] diff;

    assign diff = count_q - base_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        base_q <= '0;
        vel_q  <= '0;
      end else begin
        if (per_term) vel_q <= sat_vel(diff);
        if (zero_cntrs[i])  base_q <= '0;
        else if (per_term)  base_q <= count_q;
      end
    end

    assign vel[i*VEL_W +: VEL_W] = vel_q;
`endif
  end

endmodule

// File: tb/tb_quad_encoder_array.sv
module tb_quad_encoder_array;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 24;
  localparam int VEL_W  = 16;

  logic                    clk;
  logic                    rst;
  logic [NUM_CH-1:0]       quad_a;
  logic [NUM_CH-1:0]       quad_b;
  logic [NUM_CH-1:0]       zero_cntrs;
  logic                    snap_req;
  logic [NUM_CH*CNT_W-1:0] count;
  logic [NUM_CH*CNT_W-1:0] pos_count;
  logic [NUM_CH-1:0]       direction;
  logic [NUM_CH-1:0]       err;
  logic [NUM_CH*CNT_W-1:0] snap_count;
  logic                    snap_valid;
`ifdef ENC_VELOCITY_EN
  logic [NUM_CH*VEL_W-1:0] vel;
  logic                    vel_valid;
`endif

  quad_encoder_array #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .SYNC_STAGES(2), .FILT_LEN(4),
    .VEL_PERIOD(1000), .VEL_W(VEL_W)
  ) dut (
    .clk(clk), .rst(rst), .quad_a(quad_a), .quad_b(quad_b),
    .zero_cntrs(zero_cntrs), .snap_req(snap_req), .count(count),
    .pos_count(pos_count), .direction(direction), .err(err),
    .snap_count(snap_count), .snap_valid(snap_valid)
`ifdef ENC_VELOCITY_EN
    , .vel(vel), .vel_valid(vel_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  logic [CNT_W-1:0] c0, c1, p0, s0, s1;
  assign c0 = count[CNT_W-1:0];
  assign c1 = count[2*CNT_W-1:CNT_W];
  assign p0 = pos_count[CNT_W-1:0];
  assign s0 = snap_count[CNT_W-1:0];
  assign s1 = snap_count[2*CNT_W-1:CNT_W];

  typedef struct {
    logic [1:0]       ab;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pos;
    logic             dir;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ab(input int ch, input logic [1:0] ab);
    quad_a[ch] = ab[1];
    quad_b[ch] = ab[0];
  endtask

  function automatic logic [1:0] next_fwd(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; quad_a = '0; quad_b = '0; zero_cntrs = '0; snap_req = 1'b0;

    vecs[0]  = '{2'b01, 24'd1,  24'd1,  1'b1};
    vecs[1]  = '{2'b11, 24'd2,  24'd2,  1'b1};
    vecs[2]  = '{2'b10, 24'd3,  24'd3,  1'b1};
    vecs[3]  = '{2'b00, 24'd4,  24'd4,  1'b1};
    vecs[4]  = '{2'b01, 24'd5,  24'd5,  1'b1};
    vecs[5]  = '{2'b11, 24'd6,  24'd6,  1'b1};
    vecs[6]  = '{2'b10, 24'd7,  24'd7,  1'b1};
    vecs[7]  = '{2'b00, 24'd8,  24'd8,  1'b1};
    vecs[8]  = '{2'b10, 24'd7,  24'd9,  1'b0};
    vecs[9]  = '{2'b11, 24'd6,  24'd10, 1'b0};
    vecs[10] = '{2'b01, 24'd5,  24'd11, 1'b0};

    cyc(3);
    chk("rst_count", count[31:0], 32'h0);
    chk("rst_pos", pos_count[31:0], 32'h0);
    chk("rst_dir_err", {30'd0, direction | err}, 32'h0);
    chk("rst_snap", {31'd0, snap_valid}, 32'h0);
    rst = 1'b0;
    cyc(5);

    // Forward then reverse steps on channel 0
    for (int k = 0; k < 11; k++) begin
      set_ab(0, vecs[k].ab);
      cyc(10);
      chk($sformatf("vec%0d_count", k), {8'd0, c0}, {8'd0, vecs[k].cnt});
      chk($sformatf("vec%0d_pos", k), {8'd0, p0}, {8'd0, vecs[k].pos});
      chk($sformatf("vec%0d_dir", k), {31'd0, direction[0]}, {31'd0, vecs[k].dir});
      chk($sformatf("vec%0d_ch1", k), {8'd0, c1}, 32'h0);
    end

    // Edge latency: SYNC_STAGES + FILT_LEN + 1 = 7 edges after the sampling edge
    set_ab(0, 2'b11);
    cyc(7);
    chk("lat_early", {8'd0, c0}, 32'd5);
    cyc(1);
    chk("lat_edge", {8'd0, c0}, 32'd6);
    chk("lat_dir", {31'd0, direction[0]}, 32'd1);
    cyc(5);

    // 3-cycle glitch on A is rejected, sustained change on B is counted
    quad_a[0] = 1'b0;
    cyc(3);
    quad_a[0] = 1'b1;
    cyc(12);
    chk("glitch_count", {8'd0, c0}, 32'd6);
    chk("glitch_pos", {8'd0, p0}, 32'd12);
    set_ab(0, 2'b10);
    cyc(10);
    chk("stable_count", {8'd0, c0}, 32'd7);
    chk("stable_pos", {8'd0, p0}, 32'd13);

    // Illegal transition 10 -> 01
    set_ab(0, 2'b01);
    cyc(10);
    chk("ill_err", {31'd0, err[0]}, 32'd1);
    chk("ill_count", {8'd0, c0}, 32'd7);
    chk("ill_pos", {8'd0, p0}, 32'd13);

    // Channel 1 single forward step
    set_ab(1, 2'b01);
    cyc(10);
    chk("ch1_count", {8'd0, c1}, 32'd1);
    chk("ch1_dir", {31'd0, direction[1]}, 32'd1);

    // Zero channel 0 only
    zero_cntrs = 2'b01;
    cyc(1);
    zero_cntrs = 2'b00;
    chk("zero_count", {8'd0, c0}, 32'd0);
    chk("zero_pos", {8'd0, p0}, 32'd0);
    chk("zero_err", {31'd0, err[0]}, 32'd0);
    chk("zero_ch1", {8'd0, c1}, 32'd1);

    // Zero coincident with a decoded edge wins
    set_ab(0, 2'b11);
    cyc(7);
    zero_cntrs = 2'b01;
    cyc(1);
    zero_cntrs = 2'b00;
    chk("zero_edge_count", {8'd0, c0}, 32'd0);
    chk("zero_edge_pos", {8'd0, p0}, 32'd0);
    cyc(5);
    chk("zero_edge_late", {8'd0, c0}, 32'd0);

    // Wrap below zero and back
    set_ab(0, 2'b01);
    cyc(10);
    chk("wrap_neg", {8'd0, c0}, 32'h00FF_FFFF);
    chk("wrap_neg_pos", {8'd0, p0}, 32'd1);
    chk("wrap_neg_dir", {31'd0, direction[0]}, 32'd0);
    set_ab(0, 2'b11);
    cyc(10);
    chk("wrap_pos", {8'd0, c0}, 32'd0);
    chk("wrap_pos_pos", {8'd0, p0}, 32'd2);

    // Snapshot coincident with an edge captures the pre-edge value
    set_ab(0, 2'b10);
    cyc(10);
    set_ab(0, 2'b00);
    cyc(7);
    chk("snap_idle", {31'd0, snap_valid}, 32'd0);
    snap_req = 1'b1;
    cyc(1);
    snap_req = 1'b0;
    chk("snap_valid", {31'd0, snap_valid}, 32'd1);
    chk("snap_pre_edge", {8'd0, s0}, 32'd1);
    chk("snap_ch1", {8'd0, s1}, 32'd1);
    chk("snap_live", {8'd0, c0}, 32'd2);
    cyc(1);
    chk("snap_pulse_end", {31'd0, snap_valid}, 32'd0);
    chk("snap_hold", {8'd0, s0}, 32'd1);

    // Back-to-back requests
    snap_req = 1'b1;
    cyc(1);
    chk("b2b_first", {31'd0, snap_valid}, 32'd1);
    chk("b2b_value", {8'd0, s0}, 32'd2);
    cyc(1);
    snap_req = 1'b0;
    chk("b2b_second", {31'd0, snap_valid}, 32'd1);
    cyc(1);
    chk("b2b_end", {31'd0, snap_valid}, 32'd0);

    // Asynchronous reset while an edge is in flight
    set_ab(0, 2'b01);
    cyc(4);
    #3 rst = 1'b1;
    #1;
    chk("amid_count", count[31:0], 32'h0);
    chk("amid_count_hi", {16'd0, count[47:32]}, 32'h0);
    chk("amid_pos", pos_count[31:0], 32'h0);
    chk("amid_snap", snap_count[31:0], 32'h0);
    chk("amid_flags", {29'd0, snap_valid, direction | err}, 32'h0);
    quad_a = '0;
    quad_b = '0;
    cyc(3);
    rst = 1'b0;
    cyc(12);
    chk("post_rst_idle", count[31:0], 32'h0);
    set_ab(0, 2'b01);
    cyc(10);
    chk("post_rst_count", {8'd0, c0}, 32'd1);
    chk("post_rst_pos", {8'd0, p0}, 32'd1);

`ifdef ENC_VELOCITY_EN
    begin
      logic [1:0] ab;
      int waited;
      waited = 0;
      while (!vel_valid && waited < 1200) begin cyc(1); waited++; end
      chk("vel_first_window", {31'd0, vel_valid}, 32'd1);
      ab = 2'b01;
      for (int k = 0; k < 40; k++) begin
        ab = next_fwd(ab);
        set_ab(0, ab);
        cyc(6);
      end
      waited = 0;
      while (!vel_valid && waited < 1200) begin cyc(1); waited++; end
      chk("vel_second_window", {31'd0, vel_valid}, 32'd1);
      chk("vel_ch0", {16'd0, vel[15:0]}, 32'd40);
      chk("vel_ch1", {16'd0, vel[31:16]}, 32'd0);
      cyc(1);
      chk("vel_pulse_end", {31'd0, vel_valid}, 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
